// File: rtl/scene_reader_pipelined.sv
// Scene reader: streams pipelined triangle reads per model instance and pairs responses with its transform.
// Optional macro SCENE_READER_PREFETCH_EN adds a one-entry instance shadow that removes the IDLE bubble.
module scene_reader_pipelined #(
    parameter int unsigned MODEL_ID_W         = 8,
    parameter int unsigned TRI_IDX_W          = 16,
    parameter int unsigned TRANSFORM_W        = 288,
    parameter int unsigned TRIANGLE_W         = 288,
    parameter int unsigned MAX_OUTSTANDING    = 4,
    parameter int unsigned MAX_TRIANGLE_COUNT = 100
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   scene_in_valid,
    output logic                   scene_in_ready,
    input  logic [MODEL_ID_W-1:0]  scene_in_model_id,
    input  logic [TRANSFORM_W-1:0] scene_in_transform,
    input  logic                   scene_in_last,
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic [MODEL_ID_W-1:0]  req_model_id,
    output logic [TRI_IDX_W-1:0]   req_tri_idx,
    input  logic                   rsp_valid,
    output logic                   rsp_ready,
    input  logic [TRIANGLE_W-1:0]  rsp_triangle,
    input  logic                   rsp_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TRANSFORM_W-1:0] out_transform,
    output logic [TRIANGLE_W-1:0]  out_triangle,
    output logic                   out_triangle_last,
    output logic                   out_model_last,
    output logic                   cap_err
);
    localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned IDX_CW = TRI_IDX_W + 1;
    localparam logic [CNT_W-1:0]  OUT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [IDX_CW-1:0] IDX_CAP = IDX_CW'(MAX_TRIANGLE_COUNT);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [MODEL_ID_W-1:0]  id_q, id_d;
    logic [TRANSFORM_W-1:0] xf_q, xf_d;
    logic                   mlast_q, mlast_d;
    logic [IDX_CW-1:0]      tri_idx_q, tri_idx_d;
    logic                   seen_last_q, seen_last_d;
    logic [CNT_W-1:0]       outstanding_q, outstanding_d;
    logic                   req_valid_q, req_valid_d;
    logic                   cap_err_q, cap_err_d;
    logic                   ready_q, ready_d;

    logic                   scene_fire, req_fire, rsp_fire, rsp_dec;
    logic                   fwd, last_fire, drain_exit, load;
    logic [MODEL_ID_W-1:0]  load_id;
    logic [TRANSFORM_W-1:0] load_xf;
    logic                   load_last;

    // Response path is a zero-latency pass-through while forwarding, a sink otherwise
    assign fwd        = (state_q != IDLE) && !seen_last_q;
    assign out_valid  = fwd && rsp_valid;
    assign rsp_ready  = fwd ? out_ready : 1'b1;
    assign rsp_fire   = rsp_valid && rsp_ready;
    assign rsp_dec    = rsp_fire && (outstanding_q != '0);
    assign req_fire   = req_valid_q && req_ready;
    assign scene_fire = scene_in_valid && ready_q;
    assign last_fire  = fwd && rsp_fire && rsp_last;
    assign drain_exit = (state_q == DRAIN) && (outstanding_q == '0) && !rsp_fire && !req_valid_q;

    assign scene_in_ready    = ready_q;
    assign req_valid         = req_valid_q;
    assign req_model_id      = id_q;
    assign req_tri_idx       = TRI_IDX_W'(tri_idx_q);
    assign out_transform     = xf_q;
    assign out_triangle      = rsp_triangle;
    assign out_triangle_last = rsp_last;
    assign out_model_last    = mlast_q;
    assign cap_err           = cap_err_q;

`ifdef SCENE_READER_PREFETCH_EN
    logic                   sh_full_q, sh_full_d;
    logic [MODEL_ID_W-1:0]  sh_id_q, sh_id_d;
    logic [TRANSFORM_W-1:0] sh_xf_q, sh_xf_d;
    logic                   sh_last_q, sh_last_d;

    // An instance starts from the shadow first, so acceptance order is preserved
    assign load      = ((state_q == IDLE) || drain_exit) && (sh_full_q || scene_fire);
    assign load_id   = sh_full_q ? sh_id_q   : scene_in_model_id;
    assign load_xf   = sh_full_q ? sh_xf_q   : scene_in_transform;
    assign load_last = sh_full_q ? sh_last_q : scene_in_last;

    always_comb begin
        sh_full_d = sh_full_q;
        sh_id_d   = sh_id_q;
        sh_xf_d   = sh_xf_q;
        sh_last_d = sh_last_q;
        if (load && sh_full_q) sh_full_d = 1'b0;
        if (scene_fire && !(load && !sh_full_q)) begin
            sh_full_d = 1'b1;
            sh_id_d   = scene_in_model_id;
            sh_xf_d   = scene_in_transform;
            sh_last_d = scene_in_last;
        end
    end

    assign ready_d = !sh_full_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_full_q <= 1'b0;
            sh_id_q   <= '0;
            sh_xf_q   <= '0;
            sh_last_q <= 1'b0;
        end else begin
            sh_full_q <= sh_full_d;
            sh_id_q   <= sh_id_d;
            sh_xf_q   <= sh_xf_d;
            sh_last_q <= sh_last_d;
        end
    end
`else
    assign load      = (state_q == IDLE) && scene_fire;
    assign load_id   = scene_in_model_id;
    assign load_xf   = scene_in_transform;
    assign load_last = scene_in_last;
    assign ready_d   = (state_d == IDLE);
`endif

    // Next-state, request generation and bookkeeping
    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        xf_d          = xf_q;
        mlast_d       = mlast_q;
        tri_idx_d     = req_fire ? tri_idx_q + IDX_CW'(1) : tri_idx_q;
        seen_last_d   = seen_last_q | last_fire;
        req_valid_d   = 1'b0;
        cap_err_d     = cap_err_q | ((state_q == DRAIN) && (outstanding_q == '0) && !seen_last_q);
        outstanding_d = outstanding_q;
        if (req_fire && !rsp_dec) outstanding_d = outstanding_q + CNT_W'(1);
        else if (!req_fire && rsp_dec) outstanding_d = outstanding_q - CNT_W'(1);

        case (state_q)
            IDLE: ;
            ISSUE: begin
                if (last_fire || (tri_idx_q == IDX_CAP)) begin
                    state_d = DRAIN;
                end else begin
                    req_valid_d = (req_valid_q && !req_ready) ||
                                  ((outstanding_d < OUT_MAX) && (tri_idx_d < IDX_CAP));
                end
            end
            DRAIN: if (drain_exit) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d     = ISSUE;
            id_d        = load_id;
            xf_d        = load_xf;
            mlast_d     = load_last;
            tri_idx_d   = '0;
            seen_last_d = 1'b0;
            req_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            id_q          <= '0;
            xf_q          <= '0;
            mlast_q       <= 1'b0;
            tri_idx_q     <= '0;
            seen_last_q   <= 1'b0;
            outstanding_q <= '0;
            req_valid_q   <= 1'b0;
            cap_err_q     <= 1'b0;
            ready_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            id_q          <= id_d;
            xf_q          <= xf_d;
            mlast_q       <= mlast_d;
            tri_idx_q     <= tri_idx_d;
            seen_last_q   <= seen_last_d;
            outstanding_q <= outstanding_d;
            req_valid_q   <= req_valid_d;
            cap_err_q     <= cap_err_d;
            ready_q       <= ready_d;
        end
    end
endmodule

// File: tb/tb_scene_reader_pipelined.sv
// Bench for scene_reader_pipelined: table of instance vectors plus hand sequences for
// outstanding limit, back-to-back instances and mid-operation reset.
module tb_scene_reader_pipelined;
    localparam int W = 288;

    logic          clk, rstn;
    logic          scene_in_valid, scene_in_ready, scene_in_last;
    logic [7:0]    scene_in_model_id;
    logic [W-1:0]  scene_in_transform;
    logic          req_valid, req_ready;
    logic [7:0]    req_model_id;
    logic [15:0]   req_tri_idx;
    logic          rsp_valid, rsp_ready, rsp_last;
    logic [W-1:0]  rsp_triangle;
    logic          out_valid, out_ready, out_triangle_last, out_model_last, cap_err;
    logic [W-1:0]  out_transform, out_triangle;

    scene_reader_pipelined dut (
        .clk(clk), .rstn(rstn),
        .scene_in_valid(scene_in_valid), .scene_in_ready(scene_in_ready),
        .scene_in_model_id(scene_in_model_id), .scene_in_transform(scene_in_transform),
        .scene_in_last(scene_in_last),
        .req_valid(req_valid), .req_ready(req_ready), .req_model_id(req_model_id),
        .req_tri_idx(req_tri_idx),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_triangle(rsp_triangle),
        .rsp_last(rsp_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_transform(out_transform),
        .out_triangle(out_triangle), .out_triangle_last(out_triangle_last),
        .out_model_last(out_model_last), .cap_err(cap_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int id; int ntri; int seed; bit last; } inst_t;
    typedef struct { int id; int idx; } req_t;
    typedef struct {
        int id; int ntri; int seed; bit last; bit otog; bit rtog; int exp_beats; bit exp_cap;
    } vec_t;

    int    errors = 0, checks = 0;
    inst_t feed[$], acc[$];
    req_t  pend[$];
    int    ntri_of[256];
    int    rsp_credit = -1;
    bit    otog = 0, rtog = 0;
    int    exp_idx = 0, beats = 0, req_fires = 0, accepts = 0, max_pend = 0;
    int    mark_accept = -1, beats_at_mark = -1;
    bit    hold_prev = 0;
    logic [7:0]  prev_id;
    logic [15:0] prev_idx;
    logic [1:0]  final_flags;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] tri_data(input int id, input int idx);
        logic [7:0] b;
        b = 8'(id) ^ 8'(idx);
        return {8'(id), 16'(idx), {33{b}}};
    endfunction

    function automatic logic [W-1:0] xf(input int seed);
        logic [7:0] b;
        b = 8'(seed * 37 + 1);
        return {36{b}};
    endfunction

    function automatic bit is_last(input int id, input int idx);
        return (ntri_of[id] != 0) && (idx == ntri_of[id] - 1);
    endfunction

    task automatic push_inst(input int id, input int ntri, input int seed, input bit last);
        inst_t i;
        i.id = id; i.ntri = ntri; i.seed = seed; i.last = last;
        ntri_of[id] = ntri;
        feed.push_back(i);
    endtask

    // One clock: drive at negedge, sample 1 time unit later, fires land on the next posedge
    task automatic cycle();
        int eff;
        @(negedge clk);
        if (pend.size() > 0 && rsp_credit != 0) begin
            rsp_valid    = 1'b1;
            rsp_triangle = tri_data(pend[0].id, pend[0].idx);
            rsp_last     = is_last(pend[0].id, pend[0].idx);
        end else begin
            rsp_valid = 1'b0; rsp_triangle = '0; rsp_last = 1'b0;
        end
        req_ready = rtog ? ~req_ready : 1'b1;
        out_ready = otog ? ~out_ready : 1'b1;
        if (feed.size() > 0) begin
            scene_in_valid     = 1'b1;
            scene_in_model_id  = 8'(feed[0].id);
            scene_in_transform = xf(feed[0].seed);
            scene_in_last      = feed[0].last;
        end else begin
            scene_in_valid = 1'b0;
        end
        #1;
        if (hold_prev && req_valid) check("req_stable", {req_model_id, req_tri_idx}, {prev_id, prev_idx});
        hold_prev = req_valid && !req_ready;
        prev_id = req_model_id; prev_idx = req_tri_idx;
        if (scene_in_valid && scene_in_ready) begin
            acc.push_back(feed.pop_front());
            accepts++;
            if (accepts == mark_accept) beats_at_mark = beats;
        end
        if (out_valid && out_ready) begin
            if (acc.size() == 0) begin
                check("unexpected_beat", 1, 0);
            end else begin
                eff = (acc[0].ntri == 0) ? 100 : acc[0].ntri;
                check("out_triangle", out_triangle, tri_data(acc[0].id, exp_idx));
                check("out_transform", out_transform, xf(acc[0].seed));
                check("out_flags", {out_triangle_last, out_model_last},
                      {(acc[0].ntri != 0) && (exp_idx == eff - 1), acc[0].last});
                final_flags = {out_triangle_last, out_model_last};
                beats++; exp_idx++;
                if (exp_idx == eff) begin
                    void'(acc.pop_front());
                    exp_idx = 0;
                end
            end
        end
        if (req_valid && req_ready) begin
            req_t r;
            r.id = int'(req_model_id); r.idx = int'(req_tri_idx);
            pend.push_back(r);
            req_fires++;
        end
        if (rsp_valid && rsp_ready) begin
            void'(pend.pop_front());
            if (rsp_credit > 0) rsp_credit--;
        end
        if (pend.size() > max_pend) max_pend = pend.size();
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n = 0;
        while (!(feed.size() == 0 && acc.size() == 0 && pend.size() == 0 && scene_in_ready)) begin
            cycle();
            n++;
            if (n >= budget) begin
                check({name, "_timeout"}, 1, 0);
                break;
            end
        end
        repeat (3) cycle();
    endtask

    task automatic reset_outputs_check(input string tag);
        check({tag, "_scene_in_ready"}, scene_in_ready, 1);
        check({tag, "_req_valid"}, req_valid, 0);
        check({tag, "_req_tri_idx"}, req_tri_idx, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_cap_err"}, cap_err, 0);
    endtask

    vec_t vecs[6];

    initial begin
        int b0, f0, n;
        vecs[0] = '{id: 3,  ntri: 5,   seed: 1, last: 0, otog: 0, rtog: 0, exp_beats: 5,   exp_cap: 0};
        vecs[1] = '{id: 7,  ntri: 3,   seed: 2, last: 0, otog: 1, rtog: 1, exp_beats: 3,   exp_cap: 0};
        vecs[2] = '{id: 9,  ntri: 1,   seed: 3, last: 0, otog: 0, rtog: 0, exp_beats: 1,   exp_cap: 0};
        vecs[3] = '{id: 20, ntri: 100, seed: 4, last: 0, otog: 0, rtog: 0, exp_beats: 100, exp_cap: 0};
        vecs[4] = '{id: 11, ntri: 0,   seed: 5, last: 0, otog: 1, rtog: 0, exp_beats: 100, exp_cap: 1};
        vecs[5] = '{id: 12, ntri: 4,   seed: 6, last: 1, otog: 0, rtog: 1, exp_beats: 4,   exp_cap: 1};

        rstn = 1'b0; scene_in_valid = 0; scene_in_model_id = '0; scene_in_transform = '0;
        scene_in_last = 0; req_ready = 1; rsp_valid = 1; rsp_triangle = '0; rsp_last = 0;
        out_ready = 1;
        @(negedge clk); @(negedge clk);
        #1 reset_outputs_check("reset");
        rsp_valid = 0;
        @(negedge clk) rstn = 1'b1;

        for (int v = 0; v < 6; v++) begin
            beats = 0; max_pend = 0;
            otog = vecs[v].otog; rtog = vecs[v].rtog;
            push_inst(vecs[v].id, vecs[v].ntri, vecs[v].seed, vecs[v].last);
            run_until_idle($sformatf("vec%0d", v), 2000);
            otog = 0; rtog = 0;
            check($sformatf("vec%0d_beats", v), beats, vecs[v].exp_beats);
            check($sformatf("vec%0d_cap_err", v), cap_err, vecs[v].exp_cap);
            check($sformatf("vec%0d_max_outstanding_le4", v), max_pend <= 4, 1);
            check($sformatf("vec%0d_scene_in_ready", v), scene_in_ready, 1);
        end

        // Outstanding limit with responses held off, then a single credit
        rsp_credit = 0; beats = 0; max_pend = 0; f0 = req_fires;
        push_inst(5, 10, 7, 0);
        repeat (20) cycle();
        check("hold_req_fires", req_fires - f0, 4);
        check("hold_req_valid_low", req_valid, 0);
        rsp_credit = 1;
        repeat (10) cycle();
        check("credit_req_fires", req_fires - f0, 5);
        check("hold_max_outstanding", max_pend, 4);
        rsp_credit = -1;
        run_until_idle("hold", 500);
        check("hold_beats", beats, 10);

        // Back-to-back instances, second closes the scene
        beats = 0; mark_accept = accepts + 2; beats_at_mark = -1;
        push_inst(40, 3, 8, 0);
        push_inst(41, 2, 9, 1);
        run_until_idle("b2b", 500);
`ifdef SCENE_READER_PREFETCH_EN
        check("b2b_second_accept_beats", beats_at_mark, 0);
`else
        check("b2b_second_accept_beats", beats_at_mark, 3);
`endif
        check("b2b_beats", beats, 5);
        check("b2b_final_flags", final_flags, 2'b11);

        // Reset in the middle of ISSUE with three requests outstanding
        rsp_credit = 0;
        push_inst(30, 10, 10, 0);
        n = 0;
        while (pend.size() != 3 && n < 50) begin cycle(); n++; end
        check("pre_reset_outstanding", pend.size(), 3);
        @(negedge clk);
        rstn = 1'b0; rsp_valid = 1'b1; scene_in_valid = 1'b0;
        #1 reset_outputs_check("midreset");
        pend.delete(); acc.delete(); feed.delete();
        exp_idx = 0; hold_prev = 0; rsp_valid = 1'b0; rsp_credit = -1;
        @(negedge clk) rstn = 1'b1;
        beats = 0;
        push_inst(31, 2, 11, 0);
        run_until_idle("post_reset", 500);
        check("post_reset_beats", beats, 2);
        check("post_reset_cap_err", cap_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/scene_reader_pipelined.md
Name: scene_reader_pipelined

Overview:
- Successor to the single-request scene reader. Accepts one model instance (model id + transform) at a time from the scene buffer.
- Streams up to MAX_OUTSTANDING pipelined triangle read requests into the model buffer and pairs each returned triangle with the instance transform.
- Sits between the scene buffer and the transform stage.
- Handles in-flight requests issued past a model's last triangle, and caps runaway models.

Parameters:
MODEL_ID_W, 8, model id width
TRI_IDX_W, 16, triangle index width
TRANSFORM_W, 288, packed transform width
TRIANGLE_W, 288, packed triangle width
MAX_OUTSTANDING, 4, max requests in flight to model buffer (>=1)
MAX_TRIANGLE_COUNT, 100, hard cap on triangles per model (<= 2**TRI_IDX_W)

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
scene_in_valid  in  1  instance valid
scene_in_ready  out  1  instance accept
scene_in_model_id  in  MODEL_ID_W  model id
scene_in_transform  in  TRANSFORM_W  instance transform
scene_in_last  in  1  last instance of scene
req_valid  out  1  model buffer read request valid
req_ready  in  1  model buffer accepts request
req_model_id  out  MODEL_ID_W  requested model
req_tri_idx  out  TRI_IDX_W  requested triangle index
rsp_valid  in  1  triangle response valid, in order, one per request
rsp_ready  out  1  response accept
rsp_triangle  in  TRIANGLE_W  triangle data
rsp_last  in  1  triangle is model's last
out_valid  out  1  paired triangle valid
out_ready  in  1  downstream accept
out_transform  out  TRANSFORM_W  held instance transform
out_triangle  out  TRIANGLE_W  = rsp_triangle
out_triangle_last  out  1  = rsp_last
out_model_last  out  1  held scene_in_last
cap_err  out  1  sticky: model hit MAX_TRIANGLE_COUNT without rsp_last

Behaviour:
- Reset values: scene_in_ready=1, req_valid=0, req_tri_idx=0, out_valid=0, cap_err=0, outstanding=0, state IDLE. Reset mid-operation abandons the model. The model buffer is reset together with this block.
- States: IDLE, ISSUE, DRAIN.
- IDLE: scene_in_ready=1 and rsp_ready=1 (stray responses are dropped).
  - On scene_in fire: latch id/transform/last, tri_idx=0, clear seen_last, go to ISSUE.
  - req_valid rises the next cycle.
- ISSUE: req_valid = (outstanding < MAX_OUTSTANDING) && tri_idx < MAX_TRIANGLE_COUNT.
  - req_valid is registered-stable: once high it stays high with fixed id/idx until req_ready.
  - Each req fire increments tri_idx.
- Outstanding counter: +1 on req fire, -1 on rsp fire. Simultaneous fire leaves it unchanged. Never exceeds MAX_OUTSTANDING; never underflows.
- Response path, forwarding (ISSUE or DRAIN with !seen_last):
  - out_valid = rsp_valid; rsp_ready = out_ready.
  - Combinational pass-through, zero latency.
- Response path, discarding (seen_last set):
  - rsp_ready=1, out_valid=0.
  - Surplus responses for indices beyond the last triangle are dropped silently.
- Forwarded rsp fire with rsp_last=1:
  - Set seen_last and go to DRAIN.
  - No further requests; a req already asserted but not yet accepted is withdrawn.
- Cap reached: tri_idx==MAX_TRIANGLE_COUNT in ISSUE goes to DRAIN with seen_last still 0, forwarding remaining responses.
  - If outstanding reaches 0 in DRAIN with seen_last=0, set cap_err (sticky until reset).
- DRAIN exits when outstanding==0, no rsp firing, and req_valid=0; go to IDLE, scene_in_ready=1 the next cycle.
- A triangle with both last flags marks the end of the scene. No extra state.

Optional Feature:
SCENE_READER_PREFETCH_EN
- Defined: adds a one-entry instance shadow register. scene_in_ready = shadow empty, in any state.
  - On DRAIN exit with shadow full, go directly to ISSUE with the shadow contents (tri_idx=0, seen_last=0) and free the shadow, with no IDLE bubble.
  - Acceptance order is preserved.
- Undefined: no shadow register; scene_in_ready=1 only in IDLE, as above.

Test Plan:
- Instance id 3, model with 5 triangles, req_ready/out_ready always 1:
  - req idx 0..4 issued, plus up to MAX_OUTSTANDING-1 surplus requests.
  - Exactly 5 out beats, the last with out_triangle_last=1.
  - Surplus responses dropped, scene_in_ready returns high.
- MAX_OUTSTANDING=4, rsp held off:
  - Exactly 4 req fires, then req_valid=0.
  - Releasing one rsp allows exactly one more request.
- out_ready toggling 50% on a 3-triangle model:
  - 3 out beats, transform constant, no lost or duplicated beats.
  - Outstanding never >4.
- Model never asserting rsp_last, MAX_TRIANGLE_COUNT=100:
  - Requests stop at idx 99, 100 beats out.
  - cap_err=1 after drain; next instance is processed normally.
- Two back-to-back instances (2nd with scene_in_last=1), prefetch on vs off:
  - Without the macro: second accept occurs only after IDLE.
  - With the macro: second model's first req appears the cycle after DRAIN exit.
  - Final beat has out_model_last=1 and out_triangle_last=1.
- rstn pulsed low mid-ISSUE with 3 outstanding: all outputs at reset values immediately; a new instance is then handled cleanly.
